pad_cfg_ctrl: RTL and testbench
===============================

PAD_CFG_CTRL -- requirements
Module: pad_cfg_ctrl

Interface
REQ-001 The block SHALL have parameter NPAD, default 12: number of bidirectional pads controlled (1..16).
REQ-002 The block SHALL have parameter SETTLE, default 4: settle cycles around a drive change (1..15).
REQ-003 Port clk SHALL be input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 Port rst SHALL be input, 1 bit: asynchronous, active-high reset.
REQ-005 Port cfg_valid SHALL be input, 1 bit: a config write is offered.
REQ-006 Port cfg_ready SHALL be output, 1 bit: the block accepts a write; transfer occurs when cfg_valid & cfg_ready.
REQ-007 Port cfg_idx SHALL be input, 4 bits: target pad index.
REQ-008 Port cfg_data SHALL be input, 7 bits, with fields [0] oe, [2:1] ds (0 off, 1 E2, 2 E4, 3 E8), [3] sr, [4] smt, [6:5] pull (0 none, 1 PU, 2 PD, 3 illegal).
REQ-009 Ports pad_e, pad_e2, pad_e4, pad_e8, pad_sr, pad_smt, pad_pu and pad_pd SHALL each be outputs, NPAD bits, bit i driving the same-named pin of pad i.
REQ-010 Port busy SHALL be output, 1 bit: a write sequence is in progress.
REQ-011 Port err SHALL be output, 1 bit: one-cycle pulse flagging an illegal write.

Function
REQ-012 The controller SHALL be an FSM with states IDLE, QUIESCE, APPLY, SETTLE and ENABLE; cfg_ready = (state==IDLE) and busy = !cfg_ready.
REQ-013 On acceptance at edge T0 with pad_e[idx]=1, the block SHALL clear pad_e[idx] at T0 and enter QUIESCE for SETTLE cycles.
REQ-014 On acceptance with pad_e[idx]=0, the block SHALL skip QUIESCE and go directly to APPLY.
REQ-015 Field registers SHALL update in a single edge in APPLY (T0+1+SETTLE via QUIESCE, T0+1 otherwise): ds drives one-hot onto e2/e4/e8, and sr, smt, pu and pd are written.
REQ-016 After APPLY the block SHALL stay SETTLE cycles in SETTLE, then ENABLE SHALL write pad_e[idx]<=oe and return to IDLE on the same edge.
REQ-017 With SETTLE=4, pad_e SHALL update at T0+10 via QUIESCE and at T0+6 otherwise; cfg_ready SHALL be high in the cycle following that edge.
REQ-018 pad_pu[i] and pad_pd[i] SHALL never both be 1; pull=3 SHALL be applied as pull=0, and err SHALL pulse in the cycle after T0.
REQ-019 If cfg_idx>=NPAD, the write SHALL be accepted, err SHALL pulse after T0, no pad output SHALL change, and the FSM SHALL return to IDLE at T0+1.
REQ-020 A pad's e2/e4/e8 and pu/pd outputs SHALL never change while its pad_e is 1.
REQ-021 Only the pad addressed by cfg_idx SHALL change; all others SHALL hold.
REQ-022 cfg_idx and cfg_data SHALL be captured at acceptance, and later input changes SHALL have no effect on the sequence in progress.
REQ-023 cfg_valid while busy SHALL be ignored; the master holds it until cfg_ready.

Reset
REQ-024 While rst is asserted, the FSM SHALL be forced to IDLE asynchronously and the settle counter cleared.
REQ-025 Reset values SHALL be: pad_e=0, pad_e2=all 1, pad_e4=0, pad_e8=0, pad_sr=0, pad_smt=0, pad_pu=0, pad_pd=all 1, busy=0, err=0, cfg_ready=1 after release.
REQ-026 Reset mid-sequence SHALL abandon the write; all pads SHALL return to reset values with no partial field update retained.

Structure
REQ-027 Package pad_cfg_pkg SHALL hold the FSM state enum, the cfg_data field bit positions, the ds and pull code constants and the default SETTLE.
REQ-028 Sub-module pad_cfg_settle_cnt SHALL be used: a loadable down-counter (load SETTLE-1, done at 0) shared by QUIESCE and SETTLE.
REQ-029 Per-pad config SHALL be held in registered NPAD-wide vectors; all outputs SHALL be driven directly from flops with no combinational path to the pads.

Verification
REQ-030 Bench SHALL cover: after reset, write idx=3, data oe=1 ds=E8 pull=PU -> pad_e8[3]=1 and pad_pu[3]=1 at T0+1, pad_e[3]=1 at T0+6, ready at T0+7.
REQ-031 Bench SHALL cover: a second write to idx=3 with ds=E4 -> pad_e[3]=0 at T0, e4/e8 switch at T0+5, pad_e[3]=1 at T0+10, and e8/e4 never change while pad_e[3]=1.
REQ-032 Bench SHALL cover: write pull=3 to idx=0 -> err pulses once, pad_pu[0]=pad_pd[0]=0.
REQ-033 Bench SHALL cover: write idx=13 with NPAD=12 -> err pulses, all outputs unchanged, ready at T0+2.
REQ-034 Bench SHALL cover: cfg_valid held with changing cfg_data while busy -> only the captured write takes effect; the next write is accepted only when cfg_ready=1.
REQ-035 Bench SHALL cover: rst asserted at T0+3 of a QUIESCE sequence -> all outputs equal reset values immediately, and cfg_ready=1 after release.

Source files
------------

// File: rtl/pad_cfg_pkg.sv
// Shared types and encodings for the pad configuration controller:
// FSM states, cfg_data field layout, drive/pull codes and decode helpers.
package pad_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_QUIESCE = 3'd1,
      ST_APPLY   = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_ENABLE  = 3'd4
   } pad_state_e;

   localparam int unsigned CFG_W          = 7;
   localparam int unsigned IDX_W          = 4;
   localparam int unsigned CNT_W          = 4;
   localparam int unsigned DEFAULT_SETTLE = 4;

   localparam int unsigned CFG_OE      = 0;
   localparam int unsigned CFG_DS_LO   = 1;
   localparam int unsigned CFG_DS_HI   = 2;
   localparam int unsigned CFG_SR      = 3;
   localparam int unsigned CFG_SMT     = 4;
   localparam int unsigned CFG_PULL_LO = 5;
   localparam int unsigned CFG_PULL_HI = 6;

   localparam logic [1:0] DS_OFF = 2'd0;
   localparam logic [1:0] DS_E2  = 2'd1;
   localparam logic [1:0] DS_E4  = 2'd2;
   localparam logic [1:0] DS_E8  = 2'd3;

   localparam logic [1:0] PULL_NONE = 2'd0;
   localparam logic [1:0] PULL_PU   = 2'd1;
   localparam logic [1:0] PULL_PD   = 2'd2;
   localparam logic [1:0] PULL_ILL  = 2'd3;

   // One pad's decoded pin settings, as captured at acceptance.
   typedef struct packed {
      logic oe;
      logic e2;
      logic e4;
      logic e8;
      logic sr;
      logic smt;
      logic pu;
      logic pd;
   } pad_cfg_t;

   function automatic logic pull_illegal(input logic [CFG_W-1:0] d);
      return d[CFG_PULL_HI:CFG_PULL_LO] == PULL_ILL;
   endfunction

   // Drive strength becomes one-hot; an illegal pull code falls back to no pull.
   function automatic pad_cfg_t decode_cfg(input logic [CFG_W-1:0] d);
      pad_cfg_t c;
      c     = '0;
      c.oe  = d[CFG_OE];
      c.sr  = d[CFG_SR];
      c.smt = d[CFG_SMT];
      unique case (d[CFG_DS_HI:CFG_DS_LO])
         DS_OFF:  ;
         DS_E2:   c.e2 = 1'b1;
         DS_E4:   c.e4 = 1'b1;
         DS_E8:   c.e8 = 1'b1;
         default: ;
      endcase
      unique case (d[CFG_PULL_HI:CFG_PULL_LO])
         PULL_PU:  c.pu = 1'b1;
         PULL_PD:  c.pd = 1'b1;
         PULL_NONE,
         PULL_ILL: ;
         default:  ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pad_cfg_settle_cnt.sv
// Loadable down-counter timing the quiesce and settle windows;
// done is registered and asserts once the count reaches zero.
module pad_cfg_settle_cnt
   import pad_cfg_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             dec_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q;
   logic             done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         done_q <= 1'b1;
      end else if (load_i) begin
         cnt_q  <= load_val_i;
         done_q <= (load_val_i == '0);
      end else if (dec_i && !done_q) begin
         cnt_q  <= cnt_q - CNT_W'(1);
         done_q <= (cnt_q == CNT_W'(1));
      end
   end

   assign done_o = done_q;

endmodule

// File: rtl/pad_cfg_ctrl.sv
// Pad configuration controller: accepts one pad write at a time and applies it
// with a break-before-make sequence so drive/pull never change on an enabled pad.
module pad_cfg_ctrl
   import pad_cfg_pkg::*;
#(
   parameter int unsigned NPAD   = 12,
   parameter int unsigned SETTLE = DEFAULT_SETTLE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [CFG_W-1:0] cfg_data,
   output logic [NPAD-1:0]  pad_e,
   output logic [NPAD-1:0]  pad_e2,
   output logic [NPAD-1:0]  pad_e4,
   output logic [NPAD-1:0]  pad_e8,
   output logic [NPAD-1:0]  pad_sr,
   output logic [NPAD-1:0]  pad_smt,
   output logic [NPAD-1:0]  pad_pu,
   output logic [NPAD-1:0]  pad_pd,
   output logic             busy,
   output logic             err
);

   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);

   pad_state_e      state_q;
   logic [NPAD-1:0] mask_q;
   pad_cfg_t        cfg_q;
   logic            err_q;
   logic            ready_q;
   logic            busy_q;

   logic [NPAD-1:0] pad_e_q;
   logic [NPAD-1:0] pad_e2_q;
   logic [NPAD-1:0] pad_e4_q;
   logic [NPAD-1:0] pad_e8_q;
   logic [NPAD-1:0] pad_sr_q;
   logic [NPAD-1:0] pad_smt_q;
   logic [NPAD-1:0] pad_pu_q;
   logic [NPAD-1:0] pad_pd_q;

   logic [NPAD-1:0] acc_mask_c;
   logic            accept_c;
   logic            quiesce_c;
   logic            cnt_load_c;
   logic            cnt_dec_c;
   logic            cnt_done;

   // Replace the masked bit(s) of v with b.
   function automatic logic [NPAD-1:0] put(input logic [NPAD-1:0] v,
                                           input logic [NPAD-1:0] m,
                                           input logic            b);
      return (v & ~m) | (b ? m : '0);
   endfunction

   // An out-of-range index shifts the one-hot mask to zero, selecting no pad.
   always_comb begin
      acc_mask_c = NPAD'(1) << cfg_idx;
      accept_c   = (state_q == ST_IDLE) && cfg_valid;
      quiesce_c  = (pad_e_q & acc_mask_c) != '0;
      cnt_load_c = (accept_c && quiesce_c) ||
                   ((state_q == ST_APPLY) && (mask_q != '0));
      cnt_dec_c  = (state_q == ST_QUIESCE) || (state_q == ST_SETTLE);
   end

   pad_cfg_settle_cnt u_settle_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load_c),
      .dec_i      (cnt_dec_c),
      .load_val_i (SETTLE_LD),
      .done_o     (cnt_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         mask_q    <= '0;
         cfg_q     <= '0;
         err_q     <= 1'b0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         pad_e_q   <= '0;
         pad_e2_q  <= '1;
         pad_e4_q  <= '0;
         pad_e8_q  <= '0;
         pad_sr_q  <= '0;
         pad_smt_q <= '0;
         pad_pu_q  <= '0;
         pad_pd_q  <= '1;
      end else begin
         err_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (accept_c) begin
                  mask_q  <= acc_mask_c;
                  cfg_q   <= decode_cfg(cfg_data);
                  err_q   <= (acc_mask_c == '0) || pull_illegal(cfg_data);
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  if (quiesce_c) begin
                     pad_e_q <= pad_e_q & ~acc_mask_c;
                     state_q <= ST_QUIESCE;
                  end else begin
                     state_q <= ST_APPLY;
                  end
               end
            end
            ST_QUIESCE: begin
               if (cnt_done) state_q <= ST_APPLY;
            end
            ST_APPLY: begin
               if (mask_q == '0) begin
                  state_q <= ST_IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  // Pad is disabled here, so all drive/pull fields switch together.
                  pad_e2_q  <= put(pad_e2_q,  mask_q, cfg_q.e2);
                  pad_e4_q  <= put(pad_e4_q,  mask_q, cfg_q.e4);
                  pad_e8_q  <= put(pad_e8_q,  mask_q, cfg_q.e8);
                  pad_sr_q  <= put(pad_sr_q,  mask_q, cfg_q.sr);
                  pad_smt_q <= put(pad_smt_q, mask_q, cfg_q.smt);
                  pad_pu_q  <= put(pad_pu_q,  mask_q, cfg_q.pu);
                  pad_pd_q  <= put(pad_pd_q,  mask_q, cfg_q.pd);
                  state_q   <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (cnt_done) state_q <= ST_ENABLE;
            end
            ST_ENABLE: begin
               pad_e_q <= put(pad_e_q, mask_q, cfg_q.oe);
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_ready = ready_q;
   assign busy      = busy_q;
   assign err       = err_q;
   assign pad_e     = pad_e_q;
   assign pad_e2    = pad_e2_q;
   assign pad_e4    = pad_e4_q;
   assign pad_e8    = pad_e8_q;
   assign pad_sr    = pad_sr_q;
   assign pad_smt   = pad_smt_q;
   assign pad_pu    = pad_pu_q;
   assign pad_pd    = pad_pd_q;

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Directed bench for pad_cfg_ctrl: hand-computed pad vectors checked with
// immediate assertions at fixed cycle offsets from each accepted write.
module tb_pad_cfg_ctrl;

   localparam int unsigned NPAD = 12;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            cfg_valid = 1'b0;
   logic            cfg_ready;
   logic [3:0]      cfg_idx = '0;
   logic [6:0]      cfg_data = '0;
   logic [NPAD-1:0] pad_e, pad_e2, pad_e4, pad_e8, pad_sr, pad_smt, pad_pu, pad_pd;
   logic            busy;
   logic            err;

   int ncmp = 0;
   int nerr = 0;

   pad_cfg_ctrl #(.NPAD(NPAD), .SETTLE(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_idx   (cfg_idx),
      .cfg_data  (cfg_data),
      .pad_e     (pad_e),
      .pad_e2    (pad_e2),
      .pad_e4    (pad_e4),
      .pad_e8    (pad_e8),
      .pad_sr    (pad_sr),
      .pad_smt   (pad_smt),
      .pad_pu    (pad_pu),
      .pad_pd    (pad_pd),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_pads(input string tag,
                           input logic [NPAD-1:0] e,  input logic [NPAD-1:0] e2,
                           input logic [NPAD-1:0] e4, input logic [NPAD-1:0] e8,
                           input logic [NPAD-1:0] sr, input logic [NPAD-1:0] smt,
                           input logic [NPAD-1:0] pu, input logic [NPAD-1:0] pd);
      chk({tag, ".e"},   32'(pad_e),   32'(e));
      chk({tag, ".e2"},  32'(pad_e2),  32'(e2));
      chk({tag, ".e4"},  32'(pad_e4),  32'(e4));
      chk({tag, ".e8"},  32'(pad_e8),  32'(e8));
      chk({tag, ".sr"},  32'(pad_sr),  32'(sr));
      chk({tag, ".smt"}, 32'(pad_smt), 32'(smt));
      chk({tag, ".pu"},  32'(pad_pu),  32'(pu));
      chk({tag, ".pd"},  32'(pad_pd),  32'(pd));
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   // Presents one write for exactly one edge; returns just after acceptance edge T0.
   task automatic offer(input logic [3:0] idx, input logic [6:0] data);
      cfg_idx   = idx;
      cfg_data  = data;
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
   endtask

   // Drive/pull bits of an enabled pad must hold; pu and pd are never both set.
   logic [NPAD-1:0] p_e, p_e2, p_e4, p_e8, p_pu, p_pd;
   bit              p_ok = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         p_ok = 1'b0;
      end else begin
         if (p_ok)
            chk("stable_while_enabled",
                32'(((p_e2 ^ pad_e2) | (p_e4 ^ pad_e4) | (p_e8 ^ pad_e8) |
                     (p_pu ^ pad_pu) | (p_pd ^ pad_pd)) & p_e), 32'(0));
         chk("pu_pd_exclusive", 32'(pad_pu & pad_pd), 32'(0));
         p_e  = pad_e;
         p_e2 = pad_e2;
         p_e4 = pad_e4;
         p_e8 = pad_e8;
         p_pu = pad_pu;
         p_pd = pad_pd;
         p_ok = 1'b1;
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk_pads("reset", 12'h000, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'hFFF);
      chk("reset.ready", 32'(cfg_ready), 32'(1));
      chk("reset.busy",  32'(busy),      32'(0));
      chk("reset.err",   32'(err),       32'(0));

      // idx3 oe=1 ds=E8 pull=PU on a disabled pad: no quiesce
      offer(4'd3, 7'h27);
      chk("w1.T0.ready", 32'(cfg_ready), 32'(0));
      chk("w1.T0.busy",  32'(busy),      32'(1));
      chk("w1.T0.err",   32'(err),       32'(0));
      step();
      chk_pads("w1.T1", 12'h000, 12'hFF7, 12'h000, 12'h008, 12'h000, 12'h000, 12'h008, 12'hFF7);
      steps(4);
      chk("w1.T5.e",     32'(pad_e),     32'(0));
      chk("w1.T5.ready", 32'(cfg_ready), 32'(0));
      step();
      chk("w1.T6.e",     32'(pad_e),     32'(12'h008));
      chk("w1.T6.ready", 32'(cfg_ready), 32'(1));
      chk("w1.T6.busy",  32'(busy),      32'(0));

      // idx3 again with ds=E4: pad is enabled, so it goes through quiesce
      offer(4'd3, 7'h25);
      chk("w2.T0.e",  32'(pad_e),  32'(0));
      chk("w2.T0.e8", 32'(pad_e8), 32'(12'h008));
      steps(4);
      chk("w2.T4.e8", 32'(pad_e8), 32'(12'h008));
      chk("w2.T4.e4", 32'(pad_e4), 32'(0));
      step();
      chk_pads("w2.T5", 12'h000, 12'hFF7, 12'h008, 12'h000, 12'h000, 12'h000, 12'h008, 12'hFF7);
      steps(4);
      chk("w2.T9.e",     32'(pad_e),     32'(0));
      chk("w2.T9.ready", 32'(cfg_ready), 32'(0));
      step();
      chk("w2.T10.e",     32'(pad_e),     32'(12'h008));
      chk("w2.T10.ready", 32'(cfg_ready), 32'(1));

      // idx0 with illegal pull=3: applied as no pull, one-cycle err
      offer(4'd0, 7'h63);
      chk("w3.T0.err", 32'(err), 32'(1));
      step();
      chk("w3.T1.err", 32'(err), 32'(0));
      chk_pads("w3.T1", 12'h008, 12'hFF7, 12'h008, 12'h000, 12'h000, 12'h000, 12'h008, 12'hFF6);
      steps(5);
      chk("w3.T6.e",     32'(pad_e),     32'(12'h009));
      chk("w3.T6.ready", 32'(cfg_ready), 32'(1));

      // idx13 is out of range: err, nothing changes, ready one edge later
      offer(4'd13, 7'h7F);
      chk("w4.T0.err",   32'(err),       32'(1));
      chk("w4.T0.ready", 32'(cfg_ready), 32'(0));
      step();
      chk("w4.T1.err",   32'(err),       32'(0));
      chk("w4.T1.ready", 32'(cfg_ready), 32'(1));
      chk("w4.T1.busy",  32'(busy),      32'(0));
      chk_pads("w4.T1", 12'h009, 12'hFF7, 12'h008, 12'h000, 12'h000, 12'h000, 12'h008, 12'hFF6);

      // idx5 oe=1 ds=E8 sr smt pull=PD, valid held with changing inputs while busy
      cfg_idx   = 4'd5;
      cfg_data  = 7'h5F;
      cfg_valid = 1'b1;
      step();
      chk("w5.T0.busy", 32'(busy), 32'(1));
      for (int i = 0; i < 5; i++) begin
         cfg_idx  = 4'(i * 3);
         cfg_data = 7'(i * 37 + 1);
         step();
         chk("w5.hold.busy", 32'(busy), 32'(1));
      end
      cfg_idx  = 4'd7;
      cfg_data = 7'h00;
      step();
      chk("w5.T6.ready", 32'(cfg_ready), 32'(1));
      chk_pads("w5.T6", 12'h029, 12'hFD7, 12'h008, 12'h020, 12'h020, 12'h020, 12'h008, 12'hFF6);
      step();
      chk("w6.T0.busy", 32'(busy), 32'(1));
      cfg_valid = 1'b0;
      steps(6);
      chk("w6.T6.ready", 32'(cfg_ready), 32'(1));
      chk_pads("w6.T6", 12'h029, 12'hF57, 12'h008, 12'h020, 12'h020, 12'h020, 12'h008, 12'hF76);

      // reset in the middle of a quiesce on idx3
      offer(4'd3, 7'h27);
      chk("w7.T0.e", 32'(pad_e), 32'(12'h021));
      steps(2);
      chk("w7.T2.busy", 32'(busy), 32'(1));
      @(posedge clk);
      rst = 1'b1;
      #1;
      chk_pads("rst_mid", 12'h000, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'hFFF);
      chk("rst_mid.busy",  32'(busy),      32'(0));
      chk("rst_mid.err",   32'(err),       32'(0));
      chk("rst_mid.ready", 32'(cfg_ready), 32'(1));
      @(negedge clk);
      #2 rst = 1'b0;
      step();
      chk_pads("post_rst", 12'h000, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'hFFF);
      chk("post_rst.ready", 32'(cfg_ready), 32'(1));
      chk("post_rst.busy",  32'(busy),      32'(0));

      // normal write after the abandoned one: idx2 oe=1 ds=E2
      offer(4'd2, 7'h03);
      steps(6);
      chk("w8.T6.e",     32'(pad_e),     32'(12'h004));
      chk("w8.T6.e2",    32'(pad_e2),    32'(12'hFFF));
      chk("w8.T6.ready", 32'(cfg_ready), 32'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
